// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: M-extension funct3 codes, MDU state
// encoding and the OP/MULDIV decode constants used by the controller.
package riscv_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // R-type OP opcode; funct7 = 0000001 selects the M extension
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_multicycle.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a final sign-fix
// cycle. Divide-by-zero, signed overflow and disabled-divide requests
// bypass the iteration and complete in the cycle after accept.
module mdu_multicycle
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when neg is set (magnitude or sign restore)
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  mdu_state_t          state, state_nx;
  logic [2:0]          op;
  logic                sa, sb;
  logic [XLEN-1:0]     opr;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc;        // mul: product:multiplier, div: remainder:quotient
  logic [CW-1:0]       cnt;

  logic                accept, is_div, sgn_a_in, sgn_b_in, special;
  logic [XLEN-1:0]     special_res, fix_res;
  logic [XLEN:0]       mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0]   acc_step, prod;

  assign accept   = start && (state == MDU_IDLE || state == MDU_DONE);
  assign is_div   = func3[2];
  assign sgn_a_in = a[XLEN-1] && (func3 == MDU_MULH || func3 == MDU_MULHSU ||
                                  func3 == MDU_DIV  || func3 == MDU_REM);
  assign sgn_b_in = b[XLEN-1] && (func3 == MDU_MULH || func3 == MDU_DIV ||
                                  func3 == MDU_REM);

  // Special-case detection and result, evaluated on the raw request
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div) begin
      if (!ENABLE_DIV) begin
        special     = 1'b1;
        special_res = '0;
      end else if (b == '0) begin
        special     = 1'b1;
        special_res = func3[1] ? a : '1;
      end else if (!func3[0] && a == MIN_NEG && b == '1) begin
        special     = 1'b1;
        special_res = func3[1] ? '0 : a;
      end
    end
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opr : {XLEN{1'b0}})};
    div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_tmp - {1'b0, opr};
    if (!op[2])
      acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN])
      acc_step = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign fix and result selection
  always_comb begin
    prod = cond_neg2(acc, sa ^ sb);
    if (!op[2])
      fix_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op[1])
      fix_res = cond_neg(acc[2*XLEN-1:XLEN], sa);
    else
      fix_res = cond_neg(acc[XLEN-1:0], sa ^ sb);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      MDU_IDLE: begin
        if (accept) state_nx = special ? MDU_DONE : MDU_CALC;
      end
      MDU_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = MDU_FIX;
      end
      MDU_FIX: begin
        busy     = 1'b1;
        state_nx = MDU_DONE;
      end
      MDU_DONE: begin
        done     = 1'b1;
        state_nx = accept ? (special ? MDU_DONE : MDU_CALC) : MDU_IDLE;
      end
      default: state_nx = MDU_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opr    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op  <= func3;
      sa  <= sgn_a_in;
      sb  <= sgn_b_in;
      cnt <= CW'(XLEN - 1);
      if (is_div) begin
        opr <= cond_neg(b, sgn_b_in);
        acc <= {{XLEN{1'b0}}, cond_neg(a, sgn_a_in)};
      end else begin
        opr <= cond_neg(a, sgn_a_in);
        acc <= {{XLEN{1'b0}}, cond_neg(b, sgn_b_in)};
      end
      if (special) result <= special_res;
    end else if (state == MDU_CALC) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
    end else if (state == MDU_FIX) begin
      result <= fix_res;
    end
  end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Iterative RV32M multiply/divide unit for the multi-cycle RISC-V core, parametrised in operand width.
- Sits beside the ALU in the datapath. The controller holds in a wait state while busy is high, then writes result back through the result mux.
- Handles all eight M-extension funct3 operations with a start/busy/done handshake.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand and result width in bits (any value ≥ 4).
- ENABLE_DIV, 1, 1 = divide/remainder supported; 0 = divide ops return 0 with special-case latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand (dividend / multiplicand)
- b  input  XLEN  rs2 operand (divisor / multiplier)
- busy  output  1  high in CALC and FIX states
- done  output  1  high for exactly one cycle, in DONE state
- result  output  XLEN  registered result; held stable from DONE until the next accepted start

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0; done = 0; result = 0; all internal registers = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- Accept: start = 1 in IDLE or DONE at cycle T.
  - Latches func3, sign flags and operand magnitudes at edge T.
  - Later changes on a, b or func3 have no effect.
  - start while busy is ignored.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Remaining ops: unsigned.
  - Magnitudes are taken at accept; sign flags are stored.
- CALC: XLEN cycles (T+1 .. T+XLEN), counter from XLEN-1 down to 0.
  - Multiply: 2*XLEN-bit accumulator; add multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: restoring. Shift remainder:quotient left; subtract divisor; keep the result and set quotient bit if non-negative.
- FIX: one cycle (T+XLEN+1).
  - Negate the product if the stored signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the dividend sign.
  - Select the low XLEN bits (MUL), the high XLEN bits (MULH*), the quotient or the remainder, and register it into result.
- DONE: cycle T+XLEN+2; done = 1, busy = 0. Next state: CALC if start = 1 (back-to-back, new operands latched), else IDLE.
- Normal latency: done at T+XLEN+2.
- Special cases bypass CALC/FIX. Detection is at accept; result loads at edge T; done is high in cycle T+1.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = 100..0, b = all ones, DIV/REM): quotient = a; remainder = 0.
  - ENABLE_DIV = 0 and func3[2] = 1: result = 0.
- No exceptions or traps; all arithmetic wraps modulo 2^XLEN after sign fix.

Decomposition:
- Shared package (riscv_pkg): MDU funct3 localparams (MDU_MUL .. MDU_REMU), the MDU state encoding (2 bits), and the opcode constant for OP with funct7 = 0000001 used by the controller decode.
- Single module. The datapath is tightly coupled to the counter and FSM, so no sub-module is natural.

Test Plan:
- MUL a = 7, b = 0xFFFFFFFD (−3), start at T → done in T+34, result = 0xFFFFFFEB; busy high T+1..T+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with done at T+1. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM same operands → 0.
- Start pulses during CALC are ignored; operands change after accept with no effect. start held in the DONE cycle → second op accepted; its done arrives 34 cycles later with the correct result.
- rst asserted mid-CALC (cycle T+10) → busy = 0, done = 0, result = 0 immediately; no done pulse. Next start → normal latency and correct result.
